// File: rtl/tof_meas_sequencer.sv
// ToF range-measurement sequencer: pulses sample-start, waits for the sensor IRQ,
// reads the result over I2C (write/repeated-start/read), then clears the IRQ.
module tof_meas_sequencer #(
  parameter int NBYTES         = 2,
  parameter int SS_CYCLES      = 100,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [6:0]          dev_addr,
  input  logic [7:0]          res_idx,
  input  logic [7:0]          clr_idx,
  input  logic [7:0]          clr_val,
  output logic [2:0]          i2c_cmd,
  output logic [7:0]          i2c_din,
  output logic                i2c_wr,
  input  logic                i2c_ready,
  input  logic                i2c_ack,
  input  logic [7:0]          i2c_dout,
  output logic                tof_ss,
  input  logic                tof_irq,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [8*NBYTES-1:0] result,
  output logic [2:0]          dbg_state
);

  localparam int RW  = 8 * NBYTES;
  localparam int BCW = $clog2(NBYTES + 1);
  localparam int SCW = $clog2(SS_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);
  localparam logic [SCW-1:0] SS_LAST   = SCW'(SS_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SS     = 3'd1;
  localparam logic [2:0] S_WIRQ   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_SKIP   = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;
  localparam logic [2:0] S_FIN    = 3'd7;

  // Command steps: read burst (0..6), clear write (7..11), abort STOP (12).
  localparam logic [3:0] STP_START_R = 4'd0;
  localparam logic [3:0] STP_ADDR_W  = 4'd1;
  localparam logic [3:0] STP_RIDX    = 4'd2;
  localparam logic [3:0] STP_RESTART = 4'd3;
  localparam logic [3:0] STP_ADDR_R  = 4'd4;
  localparam logic [3:0] STP_RD      = 4'd5;
  localparam logic [3:0] STP_STOP_R  = 4'd6;
  localparam logic [3:0] STP_START_C = 4'd7;
  localparam logic [3:0] STP_ADDR_C  = 4'd8;
  localparam logic [3:0] STP_CIDX    = 4'd9;
  localparam logic [3:0] STP_CVAL    = 4'd10;
  localparam logic [3:0] STP_STOP_C  = 4'd11;
  localparam logic [3:0] STP_ABORT   = 4'd12;

  logic [2:0]     state_q, state_d;
  logic [3:0]     step_q, step_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [SCW-1:0] ss_cnt_q, ss_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]     cmd_q, cmd_d;
  logic [7:0]     din_q, din_d;
  logic [1:0]     err_q, err_d;
  logic [RW-1:0]  shadow_q, shadow_d;
  logic [RW-1:0]  result_q, result_d;
  logic           irq_s1_q, irq_s2_q;

  logic [2:0]     step_cmd;
  logic [7:0]     step_din;
  logic [RW+7:0]  shift_w;

  // Handshake: in ISSUE a command is latched only when i2c_ready=1; i2c_wr is
  // high for the single STROBE cycle, SKIP lets the master drop ready, and WAIT
  // holds cmd/din until ready returns, at which point ack/dout are valid.
  always_comb begin
    step_cmd = CMD_STOP;
    step_din = 8'h00;
    case (step_q)
      STP_START_R, STP_START_C: step_cmd = CMD_START;
      STP_ADDR_W, STP_ADDR_C: begin
        step_cmd = CMD_WR;
        step_din = {dev_addr, 1'b0};
      end
      STP_RIDX: begin
        step_cmd = CMD_WR;
        step_din = res_idx;
      end
      STP_RESTART: step_cmd = CMD_RESTART;
      STP_ADDR_R: begin
        step_cmd = CMD_WR;
        step_din = {dev_addr, 1'b1};
      end
      STP_RD: begin
        step_cmd = CMD_RD;
        step_din = (byte_q == BYTE_LAST) ? 8'h01 : 8'h00;
      end
      STP_CIDX: begin
        step_cmd = CMD_WR;
        step_din = clr_idx;
      end
      STP_CVAL: begin
        step_cmd = CMD_WR;
        step_din = clr_val;
      end
      default: step_cmd = CMD_STOP;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    byte_d   = byte_q;
    ss_cnt_d = ss_cnt_q;
    to_cnt_d = to_cnt_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    result_d = result_q;
    shift_w  = {shadow_q, i2c_dout};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = ERR_OK;
          ss_cnt_d = '0;
          shadow_d = '0;
          state_d  = S_SS;
        end
      end
      S_SS: begin
        if (ss_cnt_q == SS_LAST) begin
          to_cnt_d = '0;
          state_d  = S_WIRQ;
        end else begin
          ss_cnt_d = ss_cnt_q + 1'b1;
        end
      end
      S_WIRQ: begin
        if (irq_s2_q) begin
          step_d  = STP_START_R;
          byte_d  = '0;
          state_d = S_ISSUE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = ERR_TO;
          state_d = S_FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (i2c_ready) begin
          cmd_d   = step_cmd;
          din_d   = step_din;
          state_d = S_STROBE;
        end
      end
      S_STROBE: state_d = S_SKIP;
      S_SKIP:   state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_ready) begin
          state_d = S_ISSUE;
          if (cmd_q == CMD_WR && i2c_ack) begin
            err_d  = ERR_NACK;
            step_d = STP_ABORT;
          end else begin
            case (step_q)
              STP_RD: begin
                shadow_d = shift_w[RW-1:0];
                if (byte_q == BYTE_LAST) step_d = STP_STOP_R;
                else byte_d = byte_q + 1'b1;
              end
              STP_STOP_C, STP_ABORT: state_d = S_FIN;
              default: step_d = step_q + 4'd1;
            endcase
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result is committed on entry to FIN so it is valid alongside done.
    if (state_d == S_FIN && state_q != S_FIN && err_d == ERR_OK) result_d = shadow_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      step_q   <= STP_START_R;
      byte_q   <= '0;
      ss_cnt_q <= '0;
      to_cnt_q <= '0;
      cmd_q    <= 3'b000;
      din_q    <= 8'h00;
      err_q    <= ERR_OK;
      shadow_q <= '0;
      result_q <= '0;
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      byte_q   <= byte_d;
      ss_cnt_q <= ss_cnt_d;
      to_cnt_q <= to_cnt_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      irq_s1_q <= tof_irq;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign i2c_cmd   = cmd_q;
  assign i2c_din   = din_q;
  assign i2c_wr    = (state_q == S_STROBE);
  assign tof_ss    = (state_q == S_SS);
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tof_meas_sequencer.sv
// Bench for tof_meas_sequencer: I2C master/sensor model, command scoreboard,
// table vectors, randomized runs and reset/re-start corner sequences.
module tb_tof_meas_sequencer;

  localparam int NB  = 2;
  localparam int SSC = 4;
  localparam int TOC = 1000;

  localparam logic [2:0] C_START   = 3'b000;
  localparam logic [2:0] C_WR      = 3'b001;
  localparam logic [2:0] C_RD      = 3'b010;
  localparam logic [2:0] C_STOP    = 3'b011;
  localparam logic [2:0] C_RESTART = 3'b100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [6:0]    dev_addr = 7'h29;
  logic [7:0]    res_idx = 8'h10;
  logic [7:0]    clr_idx = 8'h0B;
  logic [7:0]    clr_val = 8'h01;
  logic [2:0]    i2c_cmd;
  logic [7:0]    i2c_din;
  logic          i2c_wr;
  logic          i2c_ready = 1'b1;
  logic          i2c_ack = 1'b0;
  logic [7:0]    i2c_dout = 8'h00;
  logic          tof_ss;
  logic          tof_irq = 1'b0;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic [8*NB-1:0] result;
  logic [2:0]    dbg_state;

  tof_meas_sequencer #(.NBYTES(NB), .SS_CYCLES(SSC), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dev_addr(dev_addr), .res_idx(res_idx), .clr_idx(clr_idx), .clr_val(clr_val),
    .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
    .i2c_ready(i2c_ready), .i2c_ack(i2c_ack), .i2c_dout(i2c_dout),
    .tof_ss(tof_ss), .tof_irq(tof_irq),
    .busy(busy), .done(done), .err(err), .result(result), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  int vec_cnt = 0;
  int mis_cnt = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  rd_q[$];
  int          cfg_lat = 1;
  int          cfg_nack = -1;
  int          wr_seen = 0;
  int          strobes = 0;
  int          viol = 0;
  int          ss_high = 0;
  int          ss_fall_cyc = 0;
  int          cyc = 0;
  int          lat_left = 0;
  logic        pend = 1'b0;
  logic        prev_wr = 1'b0;
  logic        nack_now = 1'b0;
  logic [10:0] hold = '0;

  logic [1:0]  m_err;
  logic [15:0] m_res;
  logic [15:0] last_res = 16'h0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Master model and protocol monitor; runs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        i2c_ready = 1'b1;
        pend      = 1'b0;
        lat_left  = 0;
        prev_wr   = 1'b0;
      end else begin
        if (tof_ss) begin
          ss_high++;
          ss_fall_cyc = cyc;
        end
        if (i2c_wr && (!i2c_ready || prev_wr)) viol++;
        if (pend && {i2c_cmd, i2c_din} !== hold) viol++;
        if (i2c_wr && i2c_ready) begin
          strobes++;
          hold = {i2c_cmd, i2c_din};
          pend = 1'b1;
          if (exp_q.size() == 0) begin
            vec_cnt++;
            mis_cnt++;
            $display("FAIL cmd_extra: got %0h expected none", hold);
          end else begin
            chk("cmd", 32'(hold), 32'(exp_q.pop_front()));
          end
          if (i2c_cmd == C_WR) begin
            nack_now = (wr_seen == cfg_nack);
            wr_seen++;
          end
          i2c_ready = 1'b0;
          lat_left  = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 5));
        end else if (!i2c_ready) begin
          lat_left--;
          if (lat_left <= 0) begin
            if (hold[10:8] == C_WR) i2c_ack = nack_now;
            else if (hold[10:8] == C_RD) i2c_dout = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
            i2c_ready = 1'b1;
            pend      = 1'b0;
          end
        end
        prev_wr = i2c_wr;
      end
    end
  end

  // Reference: nominal command list, truncated by an abort STOP at the NACKed write.
  task automatic model_build(input int nack, input bit tmo, input logic [7:0] b0, input logic [7:0] b1);
    logic [10:0] full[$];
    int nwr;
    bit stop_now;
    nwr = 0;
    stop_now = 1'b0;
    exp_q.delete();
    m_err = 2'b00;
    if (tmo) begin
      m_err = 2'b10;
    end else begin
      full.push_back({C_START, 8'h00});
      full.push_back({C_WR, dev_addr, 1'b0});
      full.push_back({C_WR, res_idx});
      full.push_back({C_RESTART, 8'h00});
      full.push_back({C_WR, dev_addr, 1'b1});
      for (int i = 0; i < NB; i++) full.push_back({C_RD, (i == NB - 1) ? 8'h01 : 8'h00});
      full.push_back({C_STOP, 8'h00});
      full.push_back({C_START, 8'h00});
      full.push_back({C_WR, dev_addr, 1'b0});
      full.push_back({C_WR, clr_idx});
      full.push_back({C_WR, clr_val});
      full.push_back({C_STOP, 8'h00});
      for (int i = 0; i < full.size(); i++) begin
        if (!stop_now) begin
          exp_q.push_back(full[i]);
          if (full[i][10:8] == C_WR) begin
            if (nwr == nack) begin
              exp_q.push_back({C_STOP, 8'h00});
              m_err = 2'b01;
              stop_now = 1'b1;
            end
            nwr++;
          end
        end
      end
    end
    m_res = (m_err == 2'b00) ? {b0, b1} : last_res;
  endtask

  task automatic run_seq(input string tag, input int irq_dly, input int lat, input int nack,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [1:0] e_err, input logic [15:0] e_res);
    bit got_done;
    bit tmo;
    int dly;
    tmo = (irq_dly < 0);
    model_build(nack, tmo, b0, b1);
    rd_q.delete();
    rd_q.push_back(b0);
    rd_q.push_back(b1);
    cfg_lat = lat;
    cfg_nack = nack;
    wr_seen = 0;
    strobes = 0;
    viol = 0;
    ss_high = 0;
    tof_irq = (irq_dly == 0);
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 20000 && !got_done; k++) begin
      @(negedge clk); #1;
      if (irq_dly > 0 && k == irq_dly) tof_irq = 1'b1;
      if (done) got_done = 1'b1;
    end
    if (!got_done) begin
      vec_cnt++;
      mis_cnt++;
      $display("FAIL %s_done: got no done expected done pulse", tag);
    end else begin
      chk({tag, "_err"}, 32'(err), 32'(e_err));
      chk({tag, "_result"}, 32'(result), 32'(e_res));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (tmo) begin
        dly = cyc - ss_fall_cyc;
        vec_cnt++;
        if (dly < TOC || dly > TOC + 6) begin
          mis_cnt++;
          $display("FAIL %s_timeout_delay: got %0d expected %0d..%0d", tag, dly, TOC, TOC + 6);
        end
        chk({tag, "_strobes"}, 32'(strobes), 32'd0);
      end
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_start_at_fin_ignored"}, 32'(busy), 32'd0);
      @(negedge clk); #1;
      chk({tag, "_idle_after"}, 32'({busy, tof_ss}), 32'd0);
    end
    chk({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
    chk({tag, "_ss_width"}, 32'(ss_high), 32'(SSC));
    last_res = e_res;
    tof_irq = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    int          irq_dly;
    int          lat;
    int          nack;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [1:0]  e_err;
    logic [15:0] e_res;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit to_ok;
    tbl[0] = '{50, 1, -1, 8'h12, 8'h34, 2'b00, 16'h1234};
    tbl[1] = '{50, 1, 0, 8'hAA, 8'hBB, 2'b01, 16'h1234};
    tbl[2] = '{-1, 1, -1, 8'h00, 8'h00, 2'b10, 16'h1234};
    tbl[3] = '{0, 2, -1, 8'h56, 8'h78, 2'b00, 16'h5678};
    tbl[4] = '{20, 37, -1, 8'h12, 8'h34, 2'b00, 16'h1234};
    tbl[5] = '{10, 3, 4, 8'h9A, 8'hBC, 2'b01, 16'h1234};
    tbl[6] = '{10, 2, 2, 8'hDE, 8'hF0, 2'b01, 16'h1234};

    #2;
    chk("reset_outputs", 32'({i2c_cmd, i2c_din, i2c_wr, tof_ss, busy, done, err}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_seq($sformatf("tbl%0d", i), tbl[i].irq_dly, tbl[i].lat, tbl[i].nack,
              tbl[i].b0, tbl[i].b1, tbl[i].e_err, tbl[i].e_res);

    // Re-start during the read burst, then asynchronous reset while an RD is pending.
    model_build(-1, 1'b0, 8'h12, 8'h34);
    rd_q.delete();
    rd_q.push_back(8'h12);
    rd_q.push_back(8'h34);
    cfg_lat = 37; cfg_nack = -1; wr_seen = 0; strobes = 0; viol = 0;
    tof_irq = 1'b1;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    to_ok = 1'b0;
    for (int k = 0; k < 2000 && !to_ok; k++) begin
      @(negedge clk); #1;
      if (strobes >= 6) to_ok = 1'b1;
    end
    chk("rst_reach_rd", 32'(to_ok), 32'd1);
    repeat (5) @(negedge clk);
    #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    chk("restart_ignored_ss", 32'(tof_ss), 32'd0);
    chk("restart_ignored_busy", 32'(busy), 32'd1);
    chk("restart_ignored_cmd", 32'(i2c_cmd), 32'(C_RD));
    repeat (3) @(negedge clk);
    #2; reset_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({i2c_cmd, i2c_din, i2c_wr, tof_ss, busy, done, err}), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_state", 32'(dbg_state), 32'd0);
    chk("rst_protocol", 32'(viol), 32'd0);
    tof_irq = 1'b0;
    exp_q.delete();
    rd_q.delete();
    last_res = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_seq("post_rst", 15, 1, -1, 8'h12, 8'h34, 2'b00, 16'h1234);

    for (int r = 0; r < 10; r++) begin
      int          dly;
      int          lat;
      int          nk;
      logic [7:0]  b0;
      logic [7:0]  b1;
      dly = int'($urandom_range(0, 60));
      lat = int'($urandom_range(0, 8));
      nk  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      res_idx = 8'($urandom);
      clr_idx = 8'($urandom);
      clr_val = 8'($urandom);
      model_build(nk, 1'b0, b0, b1);
      run_seq($sformatf("rnd%0d", r), dly, lat, nk, b0, b1, m_err, m_res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
